sdram_rd_sched: RTL

SDRAM_RD_SCHED -- requirements
Module: sdram_rd_sched

---
 rtl/sdram_rd_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_rd_sched.sv
// ----------------------------------------------------------------------------
// sdram_rd_sched
//   Round-robin scheduler that hands SDRAM burst reads to one of NUM_CH
//   channel FIFOs. A channel with pending data is chosen, its FIFO ready is
//   checked through the downstream selector, a burst read is requested and
//   BURST_LEN returned beats are strobed into that channel's FIFO.
//
// Parameters
//   NUM_CH      number of channels (1..20)
//   BURST_LEN   read beats per granted burst (2..65535)
//   READY_WAIT  CHECK cycles spent waiting for fifo_ready before the channel
//               is skipped (only with SDRAM_SCHED_READY_WAIT_EN defined)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   ch_req      per-channel "read data pending" flags
//   channel     registered selected channel index (drives ready selector)
//   fifo_ready  ready of the FIFO currently addressed by channel
//   rd_req      burst read request, held until rd_ack
//   rd_ack      SDRAM controller accepted rd_req
//   rd_valid    one read data beat valid
//   fifo_wr     write strobe to the selected FIFO (rd_valid while in BURST)
//   burst_done  one-cycle pulse on the final beat of a burst
//   busy        high whenever the scheduler is not IDLE
//   beat_err    sticky flag: rd_valid seen outside BURST
//
// Build option
//   SDRAM_SCHED_READY_WAIT_EN  when defined, CHECK waits up to READY_WAIT
//                              cycles for fifo_ready; otherwise CHECK lasts
//                              exactly one cycle.
// ----------------------------------------------------------------------------
module sdram_rd_sched #(
  parameter int NUM_CH     = 20,
  parameter int BURST_LEN  = 256,
  parameter int READY_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [7:0]        channel,
  input  logic              fifo_ready,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic              rd_valid,
  output logic              fifo_wr,
  output logic              burst_done,
  output logic              busy,
  output logic              beat_err
);

  if (NUM_CH < 1 || NUM_CH > 20 || BURST_LEN < 2 || BURST_LEN > 65535 || READY_WAIT < 1) begin : g_param_check
    $error("sdram_rd_sched: parameter out of range");
  end

  localparam logic [7:0]  LP_NCH       = 8'(NUM_CH);
  localparam logic [7:0]  LP_LAST_CH   = 8'(NUM_CH - 1);
  localparam logic [15:0] LP_BURST_LEN = 16'(BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_BURST
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]  r_channel;
  logic [7:0]  r_ptr;
  logic [15:0] r_beat;
  logic        r_beat_err;

  // control strobes from the next-state logic
  logic w_grant;     // load channel with the search result
  logic w_release;   // ptr <= channel (skip or burst complete)
  logic w_ack;       // request accepted, clear beat counter
  logic w_beat_en;   // count one beat

  // round-robin search
  logic [7:0]        w_start;
  logic [NUM_CH-1:0] w_rot;
  logic [7:0]        w_off;
  logic [7:0]        w_sum;
  logic [7:0]        w_pick;
  logic              w_any_req;

  logic [15:0] w_beat_inc;
  logic        w_last_beat;

  // Search begins one past ptr. Duplicating ch_req and shifting by the start
  // index puts the search order at bit 0 upward, so the lowest set bit of the
  // rotated vector is the offset of the winner. A lone requester equal to ptr
  // lands at offset NUM_CH-1 and is granted again.
  assign w_start   = (r_ptr == LP_LAST_CH) ? 8'd0 : r_ptr + 8'd1;
  assign w_rot     = NUM_CH'({ch_req, ch_req} >> w_start);
  assign w_any_req = |ch_req;

  always_comb begin
    w_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = 8'(i);
      end
    end
  end

  assign w_sum  = w_start + w_off;
  assign w_pick = (w_sum >= LP_NCH) ? w_sum - LP_NCH : w_sum;

  assign w_beat_inc  = r_beat + 16'd1;
  assign w_last_beat = (w_beat_inc == LP_BURST_LEN);

`ifdef SDRAM_SCHED_READY_WAIT_EN
  localparam logic [15:0] LP_WAIT_LAST = 16'(READY_WAIT - 1);

  // counts consecutive CHECK cycles with fifo_ready low
  logic [15:0] r_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if (r_state == ST_CHECK) begin
      r_wait <= r_wait + 16'd1;
    end else begin
      r_wait <= '0;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    w_ack       = 1'b0;
    w_beat_en   = 1'b0;
    rd_req      = 1'b0;
    fifo_wr     = 1'b0;
    burst_done  = 1'b0;
    busy        = 1'b1;

    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_any_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
`ifdef SDRAM_SCHED_READY_WAIT_EN
        if (fifo_ready) begin
          w_state_nxt = ST_REQ;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`else
        if (fifo_ready) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end

      ST_REQ: begin
        rd_req = 1'b1;
        if (rd_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_BURST;
        end
      end

      ST_BURST: begin
        fifo_wr = rd_valid;
        if (rd_valid) begin
          w_beat_en = 1'b1;
          if (w_last_beat) begin
            burst_done  = 1'b1;
            w_release   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_channel  <= '0;
      r_ptr      <= LP_LAST_CH;
      r_beat     <= '0;
      r_beat_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_channel <= w_pick;
      end
      if (w_release) begin
        r_ptr <= r_channel;
      end
      if (w_ack) begin
        r_beat <= '0;
      end else if (w_beat_en) begin
        r_beat <= w_beat_inc;
      end
      if (rd_valid && (r_state != ST_BURST)) begin
        r_beat_err <= 1'b1;
      end
    end
  end

  assign channel  = r_channel;
  assign beat_err = r_beat_err;

endmodule
